// File: rtl/job_dispatcher.sv
// Job dispatcher: queues job IDs in a FIFO and hands them one at a time to a worker FSM.
// Defining DISPATCH_TIMEOUT_EN adds a D_WAIT watchdog that completes a stuck job with cpl_err=1.
module job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [ID_W-1:0]        req_id,
    output logic                   req_ready,
    output logic                   start,
    input  logic                   worker_done,
    output logic                   cpl_valid,
    output logic [ID_W-1:0]        cpl_id,
    output logic                   cpl_err,
    input  logic                   cpl_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 5) begin : g_param_check
        $error("job_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 5");
    end

    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT, D_CPL} state_t;

    state_t          state;
    logic [ID_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [ID_W-1:0] cur_id;
    logic            done_q;
    logic            full;
    logic            push;
    logic            pop;
    logic            done_rise;

    // req_ready is forced low while reset is asserted, independent of the FIFO state.
    assign full      = (count == CW'(DEPTH));
    assign req_ready = rst_n & ~full;
    assign push      = req_valid & req_ready;
    assign pop       = (state == D_IDLE) && (count != '0);
    assign done_rise = worker_done & ~done_q;
    assign busy      = (state != D_IDLE);
    assign pending   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_id;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            cur_id <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // done_q is cleared on issue so a level left high from the previous job cannot complete the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (state == D_ISSUE) begin
            done_q <= 1'b0;
        end else begin
            done_q <= worker_done;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog;
`else
    assign cpl_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= D_IDLE;
            start     <= 1'b0;
            cpl_valid <= 1'b0;
            cpl_id    <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            cpl_err   <= 1'b0;
            wdog      <= '0;
`endif
        end else begin
            case (state)
                D_IDLE: begin
                    if (pop) begin
                        start <= 1'b1;
                        state <= D_ISSUE;
                    end
                end
                D_ISSUE: begin
                    start <= 1'b0;
                    state <= D_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                D_WAIT: begin
                    if (done_rise) begin
                        cpl_valid <= 1'b1;
                        cpl_id    <= cur_id;
                        state     <= D_CPL;
`ifdef DISPATCH_TIMEOUT_EN
                        cpl_err   <= 1'b0;
`endif
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (wdog == WD_W'(TIMEOUT)) begin
                        cpl_valid <= 1'b1;
                        cpl_id    <= cur_id;
                        cpl_err   <= 1'b1;
                        state     <= D_CPL;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                D_CPL: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        state     <= D_IDLE;
                    end
                end
                default: state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher: table-driven FIFO vectors, scoreboarded completions, corner sequences.
module tb_job_dispatcher;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 15;
    localparam int PW      = $clog2(DEPTH) + 1;

    logic            clk         = 1'b0;
    logic            rst_n       = 1'b0;
    logic            req_valid   = 1'b0;
    logic [ID_W-1:0] req_id      = '0;
    logic            req_ready;
    logic            start;
    logic            worker_done = 1'b1;
    logic            cpl_valid;
    logic [ID_W-1:0] cpl_id;
    logic            cpl_err;
    logic            cpl_ready   = 1'b1;
    logic            busy;
    logic [PW-1:0]   pending;

    job_dispatcher #(.DEPTH(DEPTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
        .req_ready(req_ready), .start(start), .worker_done(worker_done),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err),
        .cpl_ready(cpl_ready), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ID_W-1:0] id; logic err; } cpl_t;
    typedef struct { logic [ID_W-1:0] id; logic [PW-1:0] pend; logic rdy; } vec_t;

    cpl_t exp_q[$];
    vec_t vec [8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_start = -1;
    int   max_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Worker model: drops done on start, raises it 4 cycles later and holds it while idle.
    int   wcnt  = 0;
    logic stuck = 1'b0;
    logic late  = 1'b0;
    always @(negedge clk) begin
        if (start) begin
            wcnt = 1;
            worker_done = 1'b0;
        end else if (stuck) begin
            wcnt = 0;
        end else if (late) begin
            worker_done = 1'b1;
            wcnt = 0;
        end else if (wcnt == 4) begin
            worker_done = 1'b1;
            wcnt = 0;
        end else if (wcnt != 0) begin
            wcnt = wcnt + 1;
        end
    end

    // Completion scoreboard and start-spacing monitor.
    always @(negedge clk) begin
        cpl_t e;
        if (!rst_n) begin
            last_start = -1;
        end else begin
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if (start) begin
                if (last_start >= 0) check("start_gap_ge7", 32'(cyc - last_start >= 7), 32'd1);
                last_start = cyc;
            end
            if (cpl_valid && cpl_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cpl", 32'(cpl_id), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cpl_id", 32'(cpl_id), 32'(e.id));
                    check("sb_cpl_err", 32'(cpl_err), 32'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [ID_W-1:0] id, input logic err);
        int   n = 0;
        cpl_t e;
        req_valid = 1'b1;
        req_id    = id;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("push_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
        e.id  = id;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(output int t);
        int n = 0;
        @(negedge clk);
        while (!start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(start), 32'd1);
        t = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || pending != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int   t;
        int   n;
        int   starts;
        int   cpls;
        logic stable;
        logic ready_seen;
        cpl_t e;

        vec[0] = '{4'hF, 3'd1, 1'b1};
        vec[1] = '{4'h0, 3'd1, 1'b1};
        vec[2] = '{4'hA, 3'd2, 1'b1};
        vec[3] = '{4'h3, 3'd3, 1'b1};
        vec[4] = '{4'h1, 3'd1, 1'b1};
        vec[5] = '{4'h2, 3'd2, 1'b1};
        vec[6] = '{4'h3, 3'd3, 1'b1};
        vec[7] = '{4'h4, 3'd4, 1'b0};

        // Reset state, with worker_done already high.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        check("rst_cpl_id", 32'(cpl_id), 32'd0);
        check("rst_cpl_err", 32'(cpl_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("done_high_ignored", 32'(busy), 32'd0);
        tick();

        // Single job, fixed latency from start to completion.
        push_job(4'h5, 1'b0);
        wait_start(t);
        repeat (4) @(negedge clk);
        check("t4_cpl_valid", 32'(cpl_valid), 32'd0);
        @(negedge clk);
        check("t5_cpl_valid", 32'(cpl_valid), 32'd1);
        check("t5_cpl_id", 32'(cpl_id), 32'd5);
        check("t5_cpl_err", 32'(cpl_err), 32'd0);
        tick();
        wait_drain("drain_single");

        // Back-to-back pushes from idle: the first is popped immediately.
        for (int i = 0; i < 4; i++) begin
            push_job(vec[i].id, 1'b0);
            check("vec_pending", 32'(pending), 32'(vec[i].pend));
            check("vec_ready", 32'(req_ready), 32'(vec[i].rdy));
        end
        wait_drain("drain_patterns");

        // Fill the FIFO behind a job whose completion is back-pressured.
        cpl_ready = 1'b0;
        push_job(4'h9, 1'b0);
        for (int i = 4; i < 8; i++) begin
            push_job(vec[i].id, 1'b0);
            check("burst_pending", 32'(pending), 32'(vec[i].pend));
            check("burst_ready", 32'(req_ready), 32'(vec[i].rdy));
        end
        n = 0;
        @(negedge clk);
        while (!cpl_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_cpl_valid", 32'(cpl_valid), 32'd1);
        check("hold_cpl_id", 32'(cpl_id), 32'h9);
        tick();
        req_valid  = 1'b1;
        req_id     = 4'h5;
        stable     = 1'b1;
        ready_seen = 1'b0;
        starts     = 0;
        repeat (10) begin
            @(negedge clk);
            if (!cpl_valid || cpl_id != 4'h9) stable = 1'b0;
            if (start) starts++;
            if (req_ready) ready_seen = 1'b1;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_no_start", 32'(starts), 32'd0);
        check("full_ready_low", 32'(ready_seen), 32'd0);
        check("full_pending", 32'(pending), 32'd4);
        tick();
        cpl_ready = 1'b1;
        tick();
        check("ready_before_pop", 32'(req_ready), 32'd0);
        check("no_start_c1", 32'(start), 32'd0);
        tick();
        check("ready_after_pop", 32'(req_ready), 32'd1);
        check("start_2_after_release", 32'(start), 32'd1);
        tick();
        req_valid = 1'b0;
        e.id  = 4'h5;
        e.err = 1'b0;
        exp_q.push_back(e);
        wait_drain("drain_burst");

        // Reset while the first job waits on the worker and three more are queued.
        push_job(4'h6, 1'b0);
        push_job(4'h7, 1'b0);
        push_job(4'h8, 1'b0);
        push_job(4'h9, 1'b0);
        check("pre_reset_pending", 32'(pending), 32'd3);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_cpl_valid", 32'(cpl_valid), 32'd0);
        check("mid_rst_cpl_id", 32'(cpl_id), 32'd0);
        check("mid_rst_cpl_err", 32'(cpl_err), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        starts = 0;
        cpls   = 0;
        repeat (40) begin
            @(negedge clk);
            if (start) starts++;
            if (cpl_valid) cpls++;
        end
        check("post_rst_no_cpl", 32'(cpls), 32'd0);
        check("post_rst_no_start", 32'(starts), 32'd0);
        check("post_rst_pending", 32'(pending), 32'd0);
        tick();

`ifdef DISPATCH_TIMEOUT_EN
        // Worker never answers: watchdog completes with an error, late done is ignored.
        stuck = 1'b1;
        push_job(4'hC, 1'b1);
        wait_start(t);
        repeat (16) @(negedge clk);
        check("wd_t16_cpl_valid", 32'(cpl_valid), 32'd0);
        @(negedge clk);
        check("wd_cpl_valid", 32'(cpl_valid), 32'd1);
        check("wd_cpl_err", 32'(cpl_err), 32'd1);
        check("wd_cpl_id", 32'(cpl_id), 32'hC);
        tick();
        stuck = 1'b0;
        late  = 1'b1;
        cpls  = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpl_valid) cpls++;
        end
        check("wd_late_no_cpl", 32'(cpls), 32'd0);
        check("wd_late_idle", 32'(busy), 32'd0);
        tick();
        late = 1'b0;
        push_job(4'hD, 1'b0);
        wait_drain("drain_after_timeout");
`endif

        check("max_pending", 32'(max_pend), 32'd4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
